tcu: RTL and testbench

TCU -- requirements
Module: tcu

---
 rtl/tcu.sv | 133 +++++++++++++
 tb/tb_tcu.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcu.sv
// Transmit control unit: sequences SYNC, PID, optional data bytes and EOP for one packet
// on a byte-oriented shift datapath.
module tcu (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [3:0] tx_pid,
  input  logic [6:0] buffer_occupancy,
  input  logic [7:0] tx_packet_data,
  input  logic       byte_done,
  input  logic       shift_enable,
  output logic       load_byte,
  output logic [7:0] tx_byte,
  output logic       tx_data_read,
  output logic       send_eop,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  typedef enum logic [3:0] {
    IDLE,
    LOAD_SYNC,
    SEND_SYNC,
    LOAD_PID,
    SEND_PID,
    LOAD_DATA,
    SEND_DATA,
    EOP1,
    EOP2,
    EOP_IDLE,
    DONE
  } state_t;

  state_t     state_reg, state_next;
  logic [3:0] pid_q;
  logic [6:0] len_q;
  logic [6:0] cnt_reg;
  logic [7:0] byte_reg;
  logic       error_reg;

  logic       is_data;
  logic       reject;
  logic       accept;

  assign is_data = (tx_pid == 4'b0011) || (tx_pid == 4'b1011);
  assign reject  = (state_reg == IDLE) && tx_start && is_data && (buffer_occupancy > 7'd64);
  assign accept  = (state_reg == IDLE) && tx_start && !reject;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg <= IDLE;
      pid_q     <= 4'h0;
      len_q     <= 7'd0;
      cnt_reg   <= 7'd0;
      byte_reg  <= 8'h00;
      error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      error_reg <= reject;
      if (load_byte) begin
        byte_reg <= tx_byte;
      end
      if (accept) begin
        pid_q   <= tx_pid;
        len_q   <= is_data ? buffer_occupancy : 7'd0;
        cnt_reg <= is_data ? buffer_occupancy : 7'd0;
      end else if (state_reg == LOAD_DATA) begin
        cnt_reg <= cnt_reg - 7'd1;
      end
    end
  end

  // tx_byte shows the byte being loaded in LOAD_* states and holds the last loaded byte otherwise.
  always_comb begin
    state_next   = state_reg;
    load_byte    = 1'b0;
    tx_byte      = byte_reg;
    tx_data_read = 1'b0;
    send_eop     = 1'b0;
    tx_done      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = LOAD_SYNC;
      end
      LOAD_SYNC: begin
        load_byte  = 1'b1;
        tx_byte    = 8'b1000_0000;
        state_next = SEND_SYNC;
      end
      SEND_SYNC: begin
        if (byte_done) state_next = LOAD_PID;
      end
      LOAD_PID: begin
        load_byte  = 1'b1;
        tx_byte    = {~pid_q, pid_q};
        state_next = SEND_PID;
      end
      SEND_PID: begin
        if (byte_done) state_next = (len_q != 7'd0) ? LOAD_DATA : EOP1;
      end
      LOAD_DATA: begin
        load_byte    = 1'b1;
        tx_data_read = 1'b1;
        tx_byte      = tx_packet_data;
        state_next   = SEND_DATA;
      end
      SEND_DATA: begin
        if (byte_done) state_next = (cnt_reg != 7'd0) ? LOAD_DATA : EOP1;
      end
      EOP1: begin
        send_eop = 1'b1;
        if (shift_enable) state_next = EOP2;
      end
      EOP2: begin
        send_eop = 1'b1;
        if (shift_enable) state_next = EOP_IDLE;
      end
      EOP_IDLE: begin
        if (shift_enable) state_next = DONE;
      end
      DONE: begin
        tx_done    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign tx_busy  = (state_reg != IDLE);
  assign tx_error = error_reg;

endmodule

// File: tb/tb_tcu.sv
// Bench for tcu: emulates the shift datapath and TX buffer, and checks each packet against
// the byte/pulse sequence the packet rules predict.
module tb_tcu;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       tx_start;
  logic [3:0] tx_pid;
  logic [6:0] buffer_occupancy;
  logic [7:0] tx_packet_data;
  logic       byte_done;
  logic       shift_enable;
  logic       load_byte;
  logic [7:0] tx_byte;
  logic       tx_data_read;
  logic       send_eop;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;

  tcu dut (
    .clk              (clk),
    .n_rst            (n_rst),
    .tx_start         (tx_start),
    .tx_pid           (tx_pid),
    .buffer_occupancy (buffer_occupancy),
    .tx_packet_data   (tx_packet_data),
    .byte_done        (byte_done),
    .shift_enable     (shift_enable),
    .load_byte        (load_byte),
    .tx_byte          (tx_byte),
    .tx_data_read     (tx_data_read),
    .send_eop         (send_eop),
    .tx_busy          (tx_busy),
    .tx_done          (tx_done),
    .tx_error         (tx_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] pid;
    int         occ;
    bit         hold;
    bit         exp_err;
    int         exp_len;
    logic [7:0] exp_pid_byte;
  } vec_t;

  int total = 0;
  int bad   = 0;

  logic [7:0] buf_q[$];
  logic [7:0] exp_data[$];
  logic [7:0] loads[$];
  logic [7:0] junk;
  bit         in_flight;
  int         cd;
  bit         prev_read;
  int         n_read, n_done, n_err, eop_ticks, j_ticks;
  bit         eop_seen;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic bit m_is_data(input logic [3:0] p);
    return (p == 4'b0011) || (p == 4'b1011);
  endfunction

  function automatic bit m_err(input logic [3:0] p, input int occ);
    return m_is_data(p) && (occ > 64);
  endfunction

  function automatic int m_len(input logic [3:0] p, input int occ);
    return (m_is_data(p) && !m_err(p, occ)) ? occ : 0;
  endfunction

  task automatic clear_rec();
    loads.delete();
    n_read = 0; n_done = 0; n_err = 0; eop_ticks = 0; j_ticks = 0;
    eop_seen = 1'b0;
  endtask

  // One clock: apply buffer pop and datapath pulses after the edge, then sample outputs.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (prev_read && buf_q.size() > 0) junk = buf_q.pop_front();
    tx_packet_data = (buf_q.size() > 0) ? buf_q[0] : 8'h00;
    shift_enable = ($urandom_range(0, 1) == 1);
    if (in_flight) begin
      cd--;
      byte_done = (cd == 0);
      if (cd == 0) in_flight = 1'b0;
    end else begin
      byte_done = ($urandom_range(0, 7) == 0);
    end
    #1;
    prev_read = tx_data_read;
    if (tx_data_read) n_read++;
    if (load_byte) begin
      loads.push_back(tx_byte);
      in_flight = 1'b1;
      cd = $urandom_range(1, 4);
    end
    if (tx_done) n_done++;
    if (tx_error) n_err++;
    if (send_eop) begin
      eop_seen = 1'b1;
      if (shift_enable) eop_ticks++;
    end else if (eop_seen && n_done == 0 && shift_enable) begin
      j_ticks++;
    end
  endtask

  task automatic run_packet(input string name, input logic [3:0] pid, input int occ, input bit hold,
                            input bit exp_err, input int exp_len, input logic [7:0] exp_pid_byte);
    int guard;
    int busy_low;
    int busy_high;
    clear_rec();
    exp_data.delete();
    for (int i = 0; i < occ; i++) exp_data.push_back(8'($urandom));
    buf_q = exp_data;
    tx_packet_data = (buf_q.size() > 0) ? buf_q[0] : 8'h00;
    tx_pid = pid;
    buffer_occupancy = 7'(occ);
    tx_start = 1'b1;
    cycle();
    check({name, ".sync_latency"}, int'(load_byte), int'(!exp_err));
    check({name, ".busy_after_accept"}, int'(tx_busy), int'(!exp_err));
    check({name, ".error_pulse"}, int'(tx_error), int'(exp_err));
    if (!hold) tx_start = 1'b0;
    if (exp_err) begin
      busy_high = 0;
      repeat (4) begin
        cycle();
        if (tx_busy) busy_high++;
      end
      check({name, ".error_count"}, n_err, 1);
      check({name, ".rej_loads"}, loads.size(), 0);
      check({name, ".rej_busy"}, busy_high, 0);
    end else begin
      guard = 0;
      busy_low = 0;
      while (n_done == 0 && guard < 2000) begin
        tx_pid = 4'($urandom);
        buffer_occupancy = 7'($urandom);
        cycle();
        guard++;
        if (!tx_busy) busy_low++;
      end
      tx_start = 1'b0;
      check({name, ".timeout"}, int'(guard >= 2000), 0);
      repeat (2) cycle();
      check({name, ".idle_busy"}, int'(tx_busy), 0);
      check({name, ".busy_gaps"}, busy_low, 0);
      check({name, ".load_count"}, loads.size(), 2 + exp_len);
      check({name, ".sync_byte"}, (loads.size() > 0) ? int'(loads[0]) : -1, 8'h80);
      check({name, ".pid_byte"}, (loads.size() > 1) ? int'(loads[1]) : -1, int'(exp_pid_byte));
      for (int k = 0; k < exp_len; k++)
        check($sformatf("%s.data%0d", name, k),
              (loads.size() > k + 2) ? int'(loads[k + 2]) : -1, int'(exp_data[k]));
      check({name, ".reads"}, n_read, exp_len);
      check({name, ".eop_ticks"}, eop_ticks, 2);
      check({name, ".j_ticks"}, j_ticks, 1);
      check({name, ".done_count"}, n_done, 1);
      check({name, ".error_count"}, n_err, 0);
    end
    $display("packet %s pid=%0h occ=%0d hold=%0d loads=%0d reads=%0d done=%0d err=%0d",
             name, pid, occ, hold, loads.size(), n_read, n_done, n_err);
  endtask

  vec_t vecs[9];

  initial begin
    logic [3:0] rp;
    int         ro;
    bit         rh;
    int         guard;

    vecs[0] = '{pid: 4'b0010, occ: 5,   hold: 0, exp_err: 0, exp_len: 0,  exp_pid_byte: 8'hD2};
    vecs[1] = '{pid: 4'b0011, occ: 3,   hold: 0, exp_err: 0, exp_len: 3,  exp_pid_byte: 8'hC3};
    vecs[2] = '{pid: 4'b1011, occ: 65,  hold: 0, exp_err: 1, exp_len: 0,  exp_pid_byte: 8'h00};
    vecs[3] = '{pid: 4'b0011, occ: 0,   hold: 0, exp_err: 0, exp_len: 0,  exp_pid_byte: 8'hC3};
    vecs[4] = '{pid: 4'b1011, occ: 64,  hold: 0, exp_err: 0, exp_len: 64, exp_pid_byte: 8'h4B};
    vecs[5] = '{pid: 4'b0011, occ: 127, hold: 0, exp_err: 1, exp_len: 0,  exp_pid_byte: 8'h00};
    vecs[6] = '{pid: 4'b1001, occ: 10,  hold: 0, exp_err: 0, exp_len: 0,  exp_pid_byte: 8'h69};
    vecs[7] = '{pid: 4'b0101, occ: 100, hold: 0, exp_err: 0, exp_len: 0,  exp_pid_byte: 8'hA5};
    vecs[8] = '{pid: 4'b1011, occ: 2,   hold: 1, exp_err: 0, exp_len: 2,  exp_pid_byte: 8'h4B};

    n_rst = 1'b0;
    tx_start = 1'b0;
    tx_pid = 4'h0;
    buffer_occupancy = 7'd0;
    tx_packet_data = 8'h00;
    byte_done = 1'b0;
    shift_enable = 1'b0;
    in_flight = 1'b0;
    prev_read = 1'b0;
    cd = 0;
    clear_rec();
    #12;
    check("reset_outputs",
          int'({load_byte, tx_byte, tx_data_read, send_eop, tx_busy, tx_done, tx_error}), 0);
    n_rst = 1'b1;
    repeat (2) cycle();

    for (int v = 0; v < 9; v++)
      run_packet($sformatf("vec%0d", v), vecs[v].pid, vecs[v].occ, vecs[v].hold,
                 vecs[v].exp_err, vecs[v].exp_len, vecs[v].exp_pid_byte);

    // Reset asserted in the middle of a 64-byte data packet.
    clear_rec();
    exp_data.delete();
    for (int i = 0; i < 64; i++) exp_data.push_back(8'($urandom));
    buf_q = exp_data;
    tx_packet_data = buf_q[0];
    tx_pid = 4'b0011;
    buffer_occupancy = 7'd64;
    tx_start = 1'b1;
    cycle();
    tx_start = 1'b0;
    guard = 0;
    while (n_read < 10 && guard < 500) begin
      cycle();
      guard++;
    end
    check("midrst.reach_data", int'(guard >= 500), 0);
    cycle();
    #1;
    n_rst = 1'b0;
    #1;
    check("midrst.outputs",
          int'({load_byte, tx_byte, tx_data_read, send_eop, tx_busy, tx_done, tx_error}), 0);
    in_flight = 1'b0;
    prev_read = 1'b0;
    repeat (3) cycle();
    check("midrst.no_more_reads", n_read, 10);
    check("midrst.no_done", n_done, 0);
    check("midrst.busy_in_reset", int'(tx_busy), 0);
    n_rst = 1'b1;
    cycle();
    $display("packet midrst pid=3 occ=64 reads_before_reset=%0d done=%0d", n_read, n_done);
    run_packet("after_reset", 4'b1011, 5, 1'b0, 1'b0, 5, 8'h4B);

    for (int r = 0; r < 16; r++) begin
      rp = 4'($urandom);
      if ($urandom_range(0, 1) == 1) rp = ($urandom_range(0, 1) == 1) ? 4'b0011 : 4'b1011;
      ro = $urandom_range(0, 80);
      rh = !m_err(rp, ro) && ($urandom_range(0, 3) == 0);
      run_packet($sformatf("rnd%0d", r), rp, ro, rh, m_err(rp, ro), m_len(rp, ro), {~rp, rp});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
